// File: rtl/pc_pkg.sv
// Shared constants for the PC / branch unit: opcode classes, condition codes,
// flag bit positions and the branch-condition evaluator.
package pc_pkg;

    localparam logic [3:0] OPC_JMP  = 4'd7;
    localparam logic [3:0] OPC_CALL = 4'd8;
    localparam logic [3:0] OPC_RET  = 4'd9;

    localparam logic [3:0] CC_ALWAYS = 4'd0;
    localparam logic [3:0] CC_CARRY  = 4'd1;
    localparam logic [3:0] CC_ZERO   = 4'd2;
    localparam logic [3:0] CC_NEG    = 4'd3;
    localparam logic [3:0] CC_OVF    = 4'd4;
    localparam logic [3:0] CC_NZERO  = 4'd5;
    localparam logic [3:0] CC_NCARRY = 4'd6;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 3;

    // True when the jump condition holds for the current flags; 7..F never jump.
    function automatic logic cond_met(input logic [3:0] cc, input logic [3:0] flags);
        logic met;
        met = 1'b0;
        case (cc)
            CC_ALWAYS: met = 1'b1;
            CC_CARRY:  met = flags[FLAG_C];
            CC_ZERO:   met = flags[FLAG_Z];
            CC_NEG:    met = flags[FLAG_N];
            CC_OVF:    met = flags[FLAG_V];
            CC_NZERO:  met = ~flags[FLAG_Z];
            CC_NCARRY: met = ~flags[FLAG_C];
            default:   met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO. Push and pop are qualified internally by full/empty;
// dout always shows the top entry (meaningless when empty).
module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   cnt
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !do_push;
    assign wr_idx  = IDX_W'(cnt_q);
    assign rd_idx  = IDX_W'(cnt_q - CNT_W'(1));
    assign dout    = mem_q[rd_idx];
    assign cnt     = cnt_q;

    // Occupancy update.
    always_comb begin
        cnt_d = cnt_q;
        if (do_push) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (do_pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Occupancy register; contents are not reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with conditional jumps and, when PC_CALL_STACK_EN is
// defined, call/return through a return-address stack with a sticky error.
module pc_branch_unit
    import pc_pkg::*;
#(
    parameter int unsigned     PC_W        = 16,
    parameter int unsigned     STACK_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_VEC   = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               hold,
    input  logic [15:0]                        op,
    input  logic [PC_W-1:0]                    operand,
    input  logic [3:0]                         flags,
    output logic [PC_W-1:0]                    pc,
    output logic                               stack_err,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_cnt
);

    localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] target;
    logic [3:0]      opc;
    logic            unused_op;

    assign opc       = op[15:12];
    assign pc_inc    = pc_q + PC_W'(1);
    assign target    = op[7] ? (pc_q + operand) : operand;
    assign unused_op = ^op[6:0];
    assign pc        = pc_q;

`ifdef PC_CALL_STACK_EN
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [PC_W-1:0]  ret_pc;
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic             err_d;

    pc_ret_stack #(
        .W     (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (ret_pc),
        .full  (full),
        .empty (empty),
        .cnt   (cnt)
    );

    assign stack_err = err_q;
    assign stack_cnt = cnt;
`else
    assign stack_err = 1'b0;
    assign stack_cnt = CNT_W'(0);
`endif

    // Next-PC selection and stack control; hold freezes everything.
    always_comb begin
        pc_d = pc_inc;
`ifdef PC_CALL_STACK_EN
        push  = 1'b0;
        pop   = 1'b0;
        err_d = err_q;
`endif
        if (hold) begin
            pc_d = pc_q;
        end else begin
            case (opc)
                OPC_JMP: begin
                    if (cond_met(op[11:8], flags)) begin
                        pc_d = target;
                    end
                end
`ifdef PC_CALL_STACK_EN
                OPC_CALL: begin
                    if (!full) begin
                        push = 1'b1;
                        pc_d = target;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OPC_RET: begin
                    if (!empty) begin
                        pop  = 1'b1;
                        pc_d = ret_pc;
                    end else begin
                        err_d = 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef PC_CALL_STACK_EN
    // Sticky stack error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 16, meaning program counter width in bits (8..32).
REQ-002 The block SHALL have parameter STACK_DEPTH, default 4, meaning return-stack entries (1..16).
REQ-003 The block SHALL have parameter RESET_VEC, default 0, meaning the PC value loaded on reset.
REQ-004 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-006 The block SHALL have port hold, input, 1 bit, a stall that freezes the PC and ignores op.
REQ-007 The block SHALL have port op, input, 16 bits, the instruction opcode word.
REQ-008 The block SHALL have port operand, input, PC_W bits, the target address or signed offset.
REQ-009 The block SHALL have port flags, input, 4 bits: [0] zero, [1] carry, [2] negative, [3] overflow.
REQ-010 The block SHALL have port pc, output, PC_W bits, the registered program counter.
REQ-011 The block SHALL have port stack_err, output, 1 bit, a sticky overflow/underflow error.
REQ-012 The block SHALL have port stack_cnt, output, clog2(STACK_DEPTH+1) bits, the occupied entries.

Function
REQ-013 Decode: op[15:12]=7 jump; 8 call; 9 return; any other value is non-branch.
REQ-014 Jump condition op[11:8]: 0 always; 1 carry; 2 zero; 3 negative; 4 overflow; 5 not-zero; 6 not-carry; 7..F never.
REQ-015 op[7]=0 absolute: target=operand; op[7]=1 relative: target=pc+operand (two's complement, modulo 2^PC_W).
REQ-016 Taken jump: pc<=target on the next rising edge (1-cycle latency); not taken: pc<=pc+1.
REQ-017 Non-branch op: pc<=pc+1; pc at 2^PC_W-1 wraps to 0.
REQ-018 Call (unconditional, op[7] mode applies): push pc+1, pc<=target, same edge.
REQ-019 Return: pop top entry, pc<=popped value, same edge.
REQ-020 Call with stack full: no push, pc<=pc+1, stack_err<=1.
REQ-021 Return with stack empty: no pop, pc<=pc+1, stack_err<=1.
REQ-022 hold=1: pc, stack contents, stack_cnt and stack_err are unchanged regardless of op.
REQ-023 stack_err SHALL clear only on reset.
REQ-024 flags SHALL be sampled in the same cycle as op; no flag registering inside the block.

Reset
REQ-025 On a rising edge with reset=1: pc<=RESET_VEC, stack_cnt<=0, stack_err<=0; stack contents are don't-care.
REQ-026 reset has priority over hold and op, including mid call/return sequences.

Configuration
REQ-027 Macro PC_CALL_STACK_EN defined: call/return and the stack per REQ-018..021.
REQ-028 PC_CALL_STACK_EN undefined: no stack logic; opcodes 8/9 are non-branch (pc+1); stack_err and stack_cnt are tied to 0.

Structure
REQ-029 Package pc_pkg SHALL hold the opcode class constants (7/8/9), condition codes 0..6, and flag bit indices.
REQ-030 The LIFO SHALL be a sub-module, pc_ret_stack (push, pop, din, dout, full, empty, cnt), instantiated only under PC_CALL_STACK_EN.

Verification
REQ-031 Reset for 2 cycles, release, 3 idle cycles -> pc goes 0000, 0001, 0002, 0003.
REQ-032 pc=0003, op=7200, operand=0100, flags=0001 -> pc=0100; same with flags=0000 -> pc=0004.
REQ-033 pc=0010, op=7080, operand=FFFC -> pc=000C; pc=FFFF with a non-branch op -> pc=0000.
REQ-034 pc=0020, op=8000, operand=0200 -> pc=0200, stack_cnt=1; then op=9000 -> pc=0021, stack_cnt=0.
REQ-035 Five calls with STACK_DEPTH=4 -> fifth gives pc+1 and stack_err=1; return on an empty stack -> pc+1 and stack_err=1; both cases with hold=1 -> all state unchanged.
REQ-036 Rebuild without PC_CALL_STACK_EN, pc=0005, op=8000 -> pc=0006, stack_err=0.
